// File: rtl/usb_ctl_pkg.sv
// Shared definitions for the endpoint-0 control-transfer scheduler.
package usb_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    DATA,
    DRAIN,
    STATUS,
    STALL
  } ctl_state_t;

  // bmRequestType fields
  localparam int unsigned REQ_DIR_BIT  = 7;
  localparam logic [1:0]  REQ_TYPE_STD = 2'b00;

  localparam int unsigned EP0_MAX_PACKET = 64;

endpackage

// File: rtl/usb_ctl_stream_mux.sv
// 2:1 byte-stream mux between the standard and class/vendor request handlers.
// In drain mode the selected source is accepted but nothing is presented downstream.
module usb_ctl_stream_mux (
  input  logic       sel,
  input  logic       pass,
  input  logic       drain,
  input  logic       s0_tvalid,
  output logic       s0_tready,
  input  logic       s0_tlast,
  input  logic [7:0] s0_tdata,
  input  logic       s1_tvalid,
  output logic       s1_tready,
  input  logic       s1_tlast,
  input  logic [7:0] s1_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       src_tvalid,
  output logic       src_tlast
);

  logic       src_tready;
  logic [7:0] src_tdata;

  always_comb begin
    src_tvalid = sel ? s1_tvalid : s0_tvalid;
    src_tlast  = sel ? s1_tlast  : s0_tlast;
    src_tdata  = sel ? s1_tdata  : s0_tdata;
    src_tready = pass ? m_tready : drain;
    s0_tready  = src_tready & ~sel;
    s1_tready  = src_tready & sel;
    m_tvalid   = pass & src_tvalid;
    m_tdata    = m_tvalid ? src_tdata : '0;
  end

endmodule

// File: rtl/usb_ctl_xfer_sched.sv
// EP0 control-transfer scheduler: routes a SETUP to the standard or class/vendor
// handler and returns its IN stream truncated to wLength and split into packets.
module usb_ctl_xfer_sched
  import usb_ctl_pkg::*;
#(
  parameter int unsigned MAX_PACKET = EP0_MAX_PACKET,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  ctl_xfer_endpoint,
  input  logic [7:0]  ctl_xfer_type,
  input  logic [7:0]  ctl_xfer_request,
  input  logic [15:0] ctl_xfer_value,
  input  logic [15:0] ctl_xfer_index,
  input  logic [15:0] ctl_xfer_length,
  input  logic        ctl_xfer_req_i,
  output logic        ctl_xfer_gnt_o,
  output logic        ctl_stall_o,
  output logic        ctl_tvalid_o,
  input  logic        ctl_tready_i,
  output logic [7:0]  ctl_tdata_o,
  output logic        ctl_tlast_o,
  output logic        ctl_tend_o,
  output logic        ctl_zlp_o,
  output logic        std_req_o,
  input  logic        std_gnt_i,
  input  logic        std_tvalid_i,
  output logic        std_tready_o,
  input  logic        std_tlast_i,
  input  logic [7:0]  std_tdata_i,
  output logic        usr_req_o,
  input  logic        usr_gnt_i,
  input  logic        usr_tvalid_i,
  output logic        usr_tready_o,
  input  logic        usr_tlast_i,
  input  logic [7:0]  usr_tdata_i
);

  localparam int unsigned PW = $clog2(MAX_PACKET);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  ctl_state_t    state, state_nx;
  logic          sel_q, has_data_q, zlp_q;
  logic [15:0]   len_q, xfer_cnt;
  logic [PW-1:0] pkt_cnt;
  logic [TW-1:0] timer;

  logic pass, drain, src_tvalid, src_tlast;
  logic sel_gnt, hs, last_len, pkt_last, short_zlp;

  logic unused_setup;
  assign unused_setup = ^{ctl_xfer_endpoint, ctl_xfer_type[4:0], ctl_xfer_request,
                          ctl_xfer_value, ctl_xfer_index};

  assign pass      = (state == DATA);
  assign drain     = (state == DRAIN);
  assign sel_gnt   = sel_q ? usr_gnt_i : std_gnt_i;
  assign hs        = ctl_tvalid_o & ctl_tready_i;
  assign last_len  = (xfer_cnt == len_q - 16'd1);
  assign pkt_last  = &pkt_cnt;
  assign short_zlp = hs & src_tlast & ~last_len & pkt_last;

  assign ctl_tlast_o = ctl_tvalid_o & (pkt_last | src_tlast | last_len);
  assign ctl_tend_o  = ctl_tvalid_o & (src_tlast | last_len);
  assign ctl_zlp_o   = zlp_q;

  usb_ctl_stream_mux u_mux (
    .sel        (sel_q),
    .pass       (pass),
    .drain      (drain),
    .s0_tvalid  (std_tvalid_i),
    .s0_tready  (std_tready_o),
    .s0_tlast   (std_tlast_i),
    .s0_tdata   (std_tdata_i),
    .s1_tvalid  (usr_tvalid_i),
    .s1_tready  (usr_tready_o),
    .s1_tlast   (usr_tlast_i),
    .s1_tdata   (usr_tdata_i),
    .m_tvalid   (ctl_tvalid_o),
    .m_tready   (ctl_tready_i),
    .m_tdata    (ctl_tdata_o),
    .src_tvalid (src_tvalid),
    .src_tlast  (src_tlast)
  );

  // req/gnt are pure functions of the state, so the abort path clears them one cycle later.
  always_comb begin
    state_nx       = state;
    ctl_xfer_gnt_o = 1'b0;
    ctl_stall_o    = 1'b0;
    std_req_o      = 1'b0;
    usr_req_o      = 1'b0;
    case (state)
      IDLE:     state_nx = WAIT_GNT;
      WAIT_GNT: begin
        if (sel_gnt)
          state_nx = has_data_q ? DATA : STATUS;
        else if (timer == TW'(TIMEOUT - 1))
          state_nx = STALL;
      end
      DATA: begin
        if (hs && (last_len || src_tlast))
          state_nx = (last_len && !src_tlast) ? DRAIN : STATUS;
      end
      DRAIN:    if (src_tvalid && src_tlast) state_nx = STATUS;
      default:  ;
    endcase
    if (!ctl_xfer_req_i)
      state_nx = IDLE;
    if (state inside {WAIT_GNT, DATA, DRAIN, STATUS}) begin
      std_req_o = ~sel_q;
      usr_req_o = sel_q;
    end
    ctl_xfer_gnt_o = state inside {DATA, DRAIN, STATUS};
    ctl_stall_o    = (state == STALL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sel_q      <= 1'b0;
      has_data_q <= 1'b0;
      len_q      <= '0;
      timer      <= '0;
      xfer_cnt   <= '0;
      pkt_cnt    <= '0;
      zlp_q      <= 1'b0;
    end else begin
      state <= state_nx;
      zlp_q <= ctl_xfer_req_i & short_zlp;
      if (state == IDLE && ctl_xfer_req_i) begin
        sel_q      <= (ctl_xfer_type[6:5] != REQ_TYPE_STD);
        len_q      <= ctl_xfer_length;
        has_data_q <= ctl_xfer_type[REQ_DIR_BIT] & (ctl_xfer_length != '0);
      end
      timer <= (state == WAIT_GNT) ? timer + TW'(1) : '0;
      if (state_nx == IDLE) begin
        xfer_cnt <= '0;
        pkt_cnt  <= '0;
      end else if (hs) begin
        xfer_cnt <= xfer_cnt + 16'd1;
        pkt_cnt  <= pkt_cnt + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_usb_ctl_xfer_sched.sv
// Bench for usb_ctl_xfer_sched: table of directed transfers, random transfers
// against an arithmetic transfer model, plus abort and async-reset sequences.
module tb_usb_ctl_xfer_sched;

  localparam int MP = 64;
  localparam int TO = 16;

  logic        clock, reset;
  logic [3:0]  ctl_xfer_endpoint;
  logic [7:0]  ctl_xfer_type, ctl_xfer_request;
  logic [15:0] ctl_xfer_value, ctl_xfer_index, ctl_xfer_length;
  logic        ctl_xfer_req_i, ctl_xfer_gnt_o, ctl_stall_o;
  logic        ctl_tvalid_o, ctl_tready_i, ctl_tlast_o, ctl_tend_o, ctl_zlp_o;
  logic [7:0]  ctl_tdata_o;
  logic        std_req_o, std_gnt_i, std_tvalid_i, std_tready_o, std_tlast_i;
  logic [7:0]  std_tdata_i;
  logic        usr_req_o, usr_gnt_i, usr_tvalid_i, usr_tready_o, usr_tlast_i;
  logic [7:0]  usr_tdata_i;

  usb_ctl_xfer_sched #(.MAX_PACKET(MP), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ctl_xfer_endpoint(ctl_xfer_endpoint), .ctl_xfer_type(ctl_xfer_type),
    .ctl_xfer_request(ctl_xfer_request), .ctl_xfer_value(ctl_xfer_value),
    .ctl_xfer_index(ctl_xfer_index), .ctl_xfer_length(ctl_xfer_length),
    .ctl_xfer_req_i(ctl_xfer_req_i), .ctl_xfer_gnt_o(ctl_xfer_gnt_o),
    .ctl_stall_o(ctl_stall_o), .ctl_tvalid_o(ctl_tvalid_o),
    .ctl_tready_i(ctl_tready_i), .ctl_tdata_o(ctl_tdata_o),
    .ctl_tlast_o(ctl_tlast_o), .ctl_tend_o(ctl_tend_o), .ctl_zlp_o(ctl_zlp_o),
    .std_req_o(std_req_o), .std_gnt_i(std_gnt_i), .std_tvalid_i(std_tvalid_i),
    .std_tready_o(std_tready_o), .std_tlast_i(std_tlast_i), .std_tdata_i(std_tdata_i),
    .usr_req_o(usr_req_o), .usr_gnt_i(usr_gnt_i), .usr_tvalid_i(usr_tvalid_i),
    .usr_tready_o(usr_tready_o), .usr_tlast_i(usr_tlast_i), .usr_tdata_i(usr_tdata_i)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] rtype;
    int wlen, src_len, delay;
    int exp_beats, exp_tlast, exp_zlp, exp_stall;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] rtypes[6];

  int n_checks = 0, n_fail = 0;

  // per-transfer bench state and observations
  int cyc = 0;
  bit cur_sel, abort_now;
  int src_len, src_idx, gnt_delay, req_cycles;
  logic [7:0] src_bytes[$];
  int beats, tlast_cnt, zlp_cnt, last_beat_cyc, wait_start, stall_cyc;
  int gnt_in_cyc, gnt_out_cyc;
  bit zlp_late, stall_drop, stall_req, side_bad;
  int m_n, m_consumed, m_tlast, m_zlp, m_stall;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int outs();
    return int'({ctl_xfer_gnt_o, ctl_stall_o, ctl_tvalid_o, ctl_tlast_o, ctl_tend_o,
                 ctl_zlp_o, std_req_o, usr_req_o, std_tready_o, usr_tready_o, ctl_tdata_o});
  endfunction

  // Reference model: what a transfer should look like, from the request alone.
  task automatic setup_xfer(input logic [7:0] rtype, input int wlen, input int slen,
                            input int delay);
    logic [7:0] base;
    bit has_data;
    cur_sel  = (rtype[6:5] != 2'b00);
    has_data = rtype[7] && (wlen != 0);
    m_stall  = (delay >= TO) ? 1 : 0;
    m_n        = (has_data && m_stall == 0) ? ((wlen < slen) ? wlen : slen) : 0;
    m_consumed = (m_n > 0) ? slen : 0;
    m_tlast    = (m_n + MP - 1) / MP;
    m_zlp      = (m_n > 0 && slen < wlen && (m_n % MP) == 0) ? 1 : 0;
    base = 8'($urandom);
    src_bytes.delete();
    for (int i = 0; i < slen; i++) src_bytes.push_back(8'(base + 8'(i * 7)));
    src_len = slen; src_idx = 0; gnt_delay = delay; req_cycles = 0;
    beats = 0; tlast_cnt = 0; zlp_cnt = 0; last_beat_cyc = -10;
    wait_start = -1; stall_cyc = -1; gnt_in_cyc = -1; gnt_out_cyc = -1;
    zlp_late = 0; stall_drop = 0; stall_req = 0; side_bad = 0;
    ctl_xfer_endpoint = 4'd0;
    ctl_xfer_type     = rtype;
    ctl_xfer_request  = 8'($urandom);
    ctl_xfer_value    = 16'($urandom);
    ctl_xfer_index    = 16'($urandom);
    ctl_xfer_length   = 16'(wlen);
    ctl_xfer_req_i    = 1'b1;
  endtask

  // One clock cycle: drive handlers/engine at posedge+1, sample at posedge+2.
  task automatic step();
    logic my_req, gnt, sv, sl, sel_tready;
    logic [7:0] sd;
    int exp_d;
    my_req = cur_sel ? usr_req_o : std_req_o;
    if (my_req && wait_start < 0) wait_start = cyc;
    gnt = my_req && (req_cycles >= gnt_delay);
    if (my_req) req_cycles++;
    if (gnt && gnt_in_cyc < 0) gnt_in_cyc = cyc;
    sv = (src_idx < src_len) && ($urandom_range(0, 3) != 0);
    sd = 8'h00; sl = 1'b0;
    if (sv) begin
      sd = src_bytes[src_idx];
      sl = (src_idx == src_len - 1);
    end
    if (cur_sel) begin
      usr_tvalid_i = sv; usr_tlast_i = sl; usr_tdata_i = sd; usr_gnt_i = gnt;
      std_tvalid_i = 1'($urandom_range(0, 1)); std_tlast_i = 1'($urandom_range(0, 1));
      std_tdata_i = 8'($urandom); std_gnt_i = 1'($urandom_range(0, 1));
    end else begin
      std_tvalid_i = sv; std_tlast_i = sl; std_tdata_i = sd; std_gnt_i = gnt;
      usr_tvalid_i = 1'($urandom_range(0, 1)); usr_tlast_i = 1'($urandom_range(0, 1));
      usr_tdata_i = 8'($urandom); usr_gnt_i = 1'($urandom_range(0, 1));
    end
    ctl_tready_i = abort_now ? 1'b0 : ($urandom_range(0, 3) != 0);
    #1;
    if (ctl_tvalid_o && ctl_tready_i) begin
      beats++;
      exp_d = -1;
      if (beats <= src_len) exp_d = int'(src_bytes[beats-1]);
      chk("beat_data", int'(ctl_tdata_o), exp_d);
      chk("beat_tlast", int'(ctl_tlast_o), int'((beats % MP) == 0 || beats == m_n));
      chk("beat_tend", int'(ctl_tend_o), int'(beats == m_n));
      if (ctl_tlast_o) tlast_cnt++;
      last_beat_cyc = cyc;
    end
    if (ctl_zlp_o) begin
      zlp_cnt++;
      if (cyc != last_beat_cyc + 1) zlp_late = 1;
    end
    if (ctl_stall_o && stall_cyc < 0) stall_cyc = cyc;
    if (stall_cyc >= 0 && !ctl_stall_o && ctl_xfer_req_i) stall_drop = 1;
    if (ctl_stall_o && (std_req_o || usr_req_o)) stall_req = 1;
    if (ctl_xfer_gnt_o && gnt_out_cyc < 0) gnt_out_cyc = cyc;
    if (cur_sel ? (std_req_o || std_tready_o) : (usr_req_o || usr_tready_o)) side_bad = 1;
    sel_tready = cur_sel ? usr_tready_o : std_tready_o;
    if (sv && sel_tready) src_idx++;
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic run_xfer(input logic [7:0] rtype, input int wlen, input int slen,
                          input int delay, input int abort_beat);
    bit done;
    int settle;
    setup_xfer(rtype, wlen, slen, delay);
    done = 0; settle = 0;
    for (int b = 0; b < 3000 && !done; b++) begin
      step();
      if (abort_beat > 0 && beats >= abort_beat) done = 1;
      else if (stall_cyc >= 0 || (gnt_out_cyc >= 0 && src_idx >= m_consumed)) begin
        settle++;
        if (settle >= 5) done = 1;
      end
    end
    chk("xfer_done", int'(done), 1);
    if (abort_beat > 0) begin
      chk("abort_beats", beats, abort_beat);
    end else begin
      chk("beats", beats, m_n);
      chk("tlast_count", tlast_cnt, m_tlast);
      chk("zlp_count", zlp_cnt, m_zlp);
      chk("zlp_timing", int'(zlp_late), 0);
      chk("stall", int'(stall_cyc >= 0), m_stall);
      if (m_stall != 0) begin
        chk("stall_latency", stall_cyc - wait_start, TO);
        chk("stall_held", int'(stall_drop), 0);
        chk("req_in_stall", int'(stall_req), 0);
      end else begin
        chk("gnt_latency", gnt_out_cyc - gnt_in_cyc, 1);
      end
      chk("consumed", src_idx, m_consumed);
    end
    chk("wrong_port", int'(side_bad), 0);
    ctl_xfer_req_i = 1'b0;
    abort_now = 1'b1;
    step();
    abort_now = 1'b0;
    chk("idle_after_drop", outs(), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h80,    64,  18,    2,  18, 1, 0, 0};  // GET_DESCRIPTOR device
    vecs[1]  = '{8'h80,     8,  18,    0,   8, 1, 0, 0};  // truncated, drain rest
    vecs[2]  = '{8'h80,   255,  64,    3,  64, 1, 1, 0};  // short on packet boundary
    vecs[3]  = '{8'h80,   200, 100,    1, 100, 2, 0, 0};  // two packets
    vecs[4]  = '{8'h40,     4,   4, 1000,   0, 0, 0, 1};  // vendor, never granted
    vecs[5]  = '{8'h00,     0,   1,    1,   0, 0, 0, 0};  // SET_ADDRESS, no data
    vecs[6]  = '{8'hC0, 65535, 130,   15, 130, 3, 0, 0};  // grant on last timer cycle
    vecs[7]  = '{8'hA1,   128, 128,    4, 128, 2, 0, 0};  // exact fit
    vecs[8]  = '{8'h80,   300, 128,    0, 128, 2, 1, 0};
    vecs[9]  = '{8'h80,    64, 200,    2,  64, 1, 0, 0};
    vecs[10] = '{8'h80,     1,   1,    0,   1, 1, 0, 0};
    vecs[11] = '{8'h80,    64,  18,   16,   0, 0, 0, 1};  // grant one cycle too late
    rtypes = '{8'h80, 8'h00, 8'hC0, 8'h40, 8'hA1, 8'h21};

    reset = 1'b1; abort_now = 1'b0; cur_sel = 1'b0;
    ctl_xfer_endpoint = '0; ctl_xfer_type = '0; ctl_xfer_request = '0;
    ctl_xfer_value = '0; ctl_xfer_index = '0; ctl_xfer_length = '0;
    ctl_xfer_req_i = 1'b0; ctl_tready_i = 1'b0;
    std_gnt_i = 1'b0; std_tvalid_i = 1'b0; std_tlast_i = 1'b0; std_tdata_i = '0;
    usr_gnt_i = 1'b0; usr_tvalid_i = 1'b0; usr_tlast_i = 1'b0; usr_tdata_i = '0;
    src_len = 0; src_idx = 0; m_n = 0;
    #3;
    chk("reset_outputs", outs(), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      run_xfer(vecs[i].rtype, vecs[i].wlen, vecs[i].src_len, vecs[i].delay, 0);
      chk("tbl_beats", beats, vecs[i].exp_beats);
      chk("tbl_tlast", tlast_cnt, vecs[i].exp_tlast);
      chk("tbl_zlp", zlp_cnt, vecs[i].exp_zlp);
      chk("tbl_stall", int'(stall_cyc >= 0), vecs[i].exp_stall);
    end

    for (int t = 0; t < 30; t++) begin
      int wl;
      case ($urandom_range(0, 5))
        0:       wl = 0;
        1:       wl = 65535;
        2:       wl = 64;
        3:       wl = 128;
        default: wl = int'($urandom_range(1, 200));
      endcase
      run_xfer(rtypes[$urandom_range(0, 5)], wl, int'($urandom_range(1, 150)),
               int'($urandom_range(0, 19)), 0);
    end

    // req_i withdrawn after beat 5 of an 18-byte descriptor
    run_xfer(8'h80, 64, 18, 1, 5);

    // asynchronous reset while bytes are streaming
    setup_xfer(8'h80, 64, 18, 0);
    for (int b = 0; b < 500 && beats < 3; b++) step();
    chk("pre_reset_beats", beats, 3);
    std_tvalid_i = 1'b1; std_tlast_i = 1'b0; std_tdata_i = 8'hA5; ctl_tready_i = 1'b1;
    #1;
    chk("pre_reset_tvalid", int'(ctl_tvalid_o), 1);
    chk("pre_reset_tdata", int'(ctl_tdata_o), 8'hA5);
    #1 reset = 1'b1;
    #1;
    chk("reset_async_clear", outs(), 0);
    ctl_xfer_req_i = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("idle_after_reset", outs(), 0);
    run_xfer(8'h80, 64, 18, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
